// File: rtl/pulse_gen_pkg.sv
// ---------------------------------------------------------------------------
// pulse_gen_pkg
// Shared definitions for the pulse/burst generator:
//   - state_t   : FSM state encoding (IDLE, DELAY, HIGH, GAP)
//   - PG_CW     : default width of the delay/length/gap fields and counter
//   - PG_RW     : default width of the repetition-count field
//   - is_last() : true when the pulse now ending is the final one of a burst
// ---------------------------------------------------------------------------
package pulse_gen_pkg;

   localparam int PG_CW = 16;
   localparam int PG_RW = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_HIGH  = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   // A continuous burst never has a last pulse; otherwise the pulse that ends
   // with one repetition remaining is the last.
   function automatic logic is_last(input logic [31:0] rem, input logic continuous);
      return !continuous && (rem == 32'd1);
   endfunction

endpackage

// File: rtl/pulse_cnt_dn.sv
// ---------------------------------------------------------------------------
// pulse_cnt_dn
// Loadable down-counter that saturates at zero.
// Ports:
//   i_clk      : clock, posedge
//   i_rstn     : asynchronous active-low reset (counter -> 0)
//   i_load     : load i_load_val (has priority over i_en)
//   i_load_val : value to load
//   i_en       : decrement by one when the count is non-zero
//   o_zero     : count is zero
// ---------------------------------------------------------------------------
module pulse_cnt_dn
   import pulse_gen_pkg::*;
#(
   parameter int CW = PG_CW
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic          i_load,
   input  logic [CW-1:0] i_load_val,
   input  logic          i_en,
   output logic          o_zero
);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CW'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pulse_gen.sv
// ---------------------------------------------------------------------------
// pulse_gen
// Programmable single-channel pulse/burst generator. A start strobe latches
// the configuration, waits i_dly cycles, then emits i_reps pulses of i_len
// high cycles separated by i_gap low cycles (i_reps=0: run until i_abort).
// Ports:
//   i_clk    : clock, posedge
//   i_rstn   : asynchronous active-low reset
//   i_start  : 1-cycle start strobe, accepted only when idle
//   i_abort  : stop immediately, no done; beats i_start
//   i_dly    : cycles from the start edge to the first pulse rise
//   i_len    : high cycles per pulse (0: no pulse at all)
//   i_gap    : low cycles between pulses (0: pulses merge)
//   i_reps   : pulse count (0: continuous)
//   o_pulse  : registered pulse output
//   o_busy   : FSM not idle
//   o_done   : registered 1-cycle strobe on normal completion
// ---------------------------------------------------------------------------
module pulse_gen
   import pulse_gen_pkg::*;
#(
   parameter int CW = PG_CW,
   parameter int RW = PG_RW
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic          i_start,
   input  logic          i_abort,
   input  logic [CW-1:0] i_dly,
   input  logic [CW-1:0] i_len,
   input  logic [CW-1:0] i_gap,
   input  logic [RW-1:0] i_reps,
   output logic          o_pulse,
   output logic          o_busy,
   output logic          o_done
);

   state_t        r_state;
   state_t        w_state_next;
   logic          r_pulse;
   logic          w_pulse_next;
   logic          r_done;
   logic          w_done_next;
   logic [RW-1:0] r_rem;
   logic [RW-1:0] w_rem_next;
   logic [CW-1:0] r_len;
   logic [CW-1:0] r_gap;
   logic [RW-1:0] r_reps;
   logic          w_latch;
   logic          w_cnt_load;
   logic [CW-1:0] w_cnt_load_val;
   logic          w_cnt_en;
   logic          w_cnt_zero;
   logic          w_cont;
   logic          w_last;

   pulse_cnt_dn #(.CW(CW)) u_cnt (
      .i_clk      (i_clk),
      .i_rstn     (i_rstn),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_load_val),
      .i_en       (w_cnt_en),
      .o_zero     (w_cnt_zero)
   );

   assign w_cont = (r_reps == '0);
   assign w_last = is_last(32'(r_rem), w_cont);

   always_comb begin
      w_state_next   = r_state;
      w_pulse_next   = r_pulse;
      w_done_next    = 1'b0;
      w_rem_next     = r_rem;
      w_latch        = 1'b0;
      w_cnt_load     = 1'b0;
      w_cnt_load_val = '0;
      w_cnt_en       = 1'b0;

      if (i_abort) begin
         // Loading zero clears the counter along with everything else.
         w_state_next = ST_IDLE;
         w_pulse_next = 1'b0;
         w_rem_next   = '0;
         w_cnt_load   = 1'b1;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  w_latch    = 1'b1;
                  w_rem_next = i_reps;
                  if (i_dly != '0) begin
                     w_state_next   = ST_DELAY;
                     w_cnt_load     = 1'b1;
                     w_cnt_load_val = i_dly - CW'(1);
                  end else if (i_len != '0) begin
                     w_state_next   = ST_HIGH;
                     w_pulse_next   = 1'b1;
                     w_cnt_load     = 1'b1;
                     w_cnt_load_val = i_len - CW'(1);
                  end else begin
                     w_done_next = 1'b1;
                  end
               end
            end
            ST_DELAY: begin
               if (!w_cnt_zero) begin
                  w_cnt_en = 1'b1;
               end else if (r_len != '0) begin
                  w_state_next   = ST_HIGH;
                  w_pulse_next   = 1'b1;
                  w_cnt_load     = 1'b1;
                  w_cnt_load_val = r_len - CW'(1);
               end else begin
                  w_state_next = ST_IDLE;
                  w_done_next  = 1'b1;
               end
            end
            ST_HIGH: begin
               if (!w_cnt_zero) begin
                  w_cnt_en = 1'b1;
               end else if (w_last) begin
                  w_state_next = ST_IDLE;
                  w_pulse_next = 1'b0;
                  w_done_next  = 1'b1;
               end else begin
                  // Continuous mode keeps rem at its loaded value of zero.
                  if (!w_cont) begin
                     w_rem_next = r_rem - RW'(1);
                  end
                  w_cnt_load = 1'b1;
                  if (r_gap == '0) begin
                     w_cnt_load_val = r_len - CW'(1);
                  end else begin
                     w_state_next   = ST_GAP;
                     w_pulse_next   = 1'b0;
                     w_cnt_load_val = r_gap - CW'(1);
                  end
               end
            end
            ST_GAP: begin
               if (!w_cnt_zero) begin
                  w_cnt_en = 1'b1;
               end else begin
                  w_state_next   = ST_HIGH;
                  w_pulse_next   = 1'b1;
                  w_cnt_load     = 1'b1;
                  w_cnt_load_val = r_len - CW'(1);
               end
            end
            default: begin
               w_state_next = ST_IDLE;
               w_pulse_next = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state <= ST_IDLE;
         r_pulse <= 1'b0;
         r_done  <= 1'b0;
         r_rem   <= '0;
         r_len   <= '0;
         r_gap   <= '0;
         r_reps  <= '0;
      end else begin
         r_state <= w_state_next;
         r_pulse <= w_pulse_next;
         r_done  <= w_done_next;
         r_rem   <= w_rem_next;
         if (w_latch) begin
            r_len  <= i_len;
            r_gap  <= i_gap;
            r_reps <= i_reps;
         end
      end
   end

   assign o_pulse = r_pulse;
   assign o_done  = r_done;
   assign o_busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pulse_gen.sv
module tb_pulse_gen;

   logic        clk;
   logic        rstn;
   logic        start;
   logic        abort;
   logic [15:0] dly;
   logic [15:0] len;
   logic [15:0] gap;
   logic [7:0]  reps;
   logic        pulse;
   logic        busy;
   logic        done;

   int n_tests = 0;
   int n_fail  = 0;
   int burst_id = 0;

   // Expected {pulse, busy, done} sampled after edges E0, E0+1, ...
   logic [2:0] exp_q[$];

   pulse_gen #(.CW(16), .RW(8)) dut (
      .i_clk   (clk),
      .i_rstn  (rstn),
      .i_start (start),
      .i_abort (abort),
      .i_dly   (dly),
      .i_len   (len),
      .i_gap   (gap),
      .i_reps  (reps),
      .o_pulse (pulse),
      .o_busy  (busy),
      .o_done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [2:0] got, input logic [2:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s pulse/busy/done got=%b exp=%b", tag, got, exp);
      end
   endtask

   // Reference waveform from the timing rules: dly waiting cycles, then
   // reps x (len high), separated by gap low cycles, then one done cycle.
   // Continuous bursts are generated until at least min_len entries exist.
   task automatic build_model(input int d, input int l, input int g, input int r, input int min_len);
      exp_q.delete();
      for (int k = 0; k < d; k++) exp_q.push_back(3'b010);
      if (l == 0) begin
         exp_q.push_back(3'b001);
      end else if (r == 0) begin
         while (exp_q.size() < min_len) begin
            for (int k = 0; k < l; k++) exp_q.push_back(3'b110);
            for (int k = 0; k < g; k++) exp_q.push_back(3'b010);
         end
      end else begin
         for (int p = 0; p < r; p++) begin
            for (int k = 0; k < l; k++) exp_q.push_back(3'b110);
            if (p < r - 1)
               for (int k = 0; k < g; k++) exp_q.push_back(3'b010);
         end
         exp_q.push_back(3'b001);
      end
   endtask

   // Abort at edge E0+a: everything from that sample onward is idle.
   task automatic apply_abort(input int a);
      while (exp_q.size() > a) void'(exp_q.pop_back());
      exp_q.push_back(3'b000);
   endtask

   // Called at a negedge; returns at the negedge after the last check.
   task automatic run_burst(input int d, input int l, input int g, input int r,
                            input int abort_at, input int busy_start_at, input int tail);
      int n;
      burst_id++;
      n = exp_q.size();
      $display("[TB] burst %0d: dly=%0d len=%0d gap=%0d reps=%0d abort_at=%0d busy_start_at=%0d",
               burst_id, d, l, g, r, abort_at, busy_start_at);
      dly   = 16'(d);
      len   = 16'(l);
      gap   = 16'(g);
      reps  = 8'(r);
      start = 1'b1;
      abort = (abort_at == 0);
      for (int k = 0; k < n + tail; k++) begin
         @(posedge clk);
         @(negedge clk);
         check_eq($sformatf("b%0d_k%0d", burst_id, k), {pulse, busy, done},
                  (k < n) ? exp_q[k] : 3'b000);
         // Scrambled config while busy must not disturb the running burst.
         start = (k + 1 == busy_start_at);
         abort = (k + 1 == abort_at);
         dly   = 16'($urandom_range(0, 7));
         len   = 16'($urandom_range(0, 7));
         gap   = 16'($urandom_range(0, 7));
         reps  = 8'($urandom_range(0, 7));
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   // Picks an edge index at which start arrives while the FSM is busy.
   function automatic int pick_busy_start();
      int j;
      if (exp_q.size() < 2) return -1;
      j = $urandom_range(1, exp_q.size() - 1);
      if (exp_q[j-1][1] == 1'b1) return j;
      return -1;
   endfunction

   initial begin
      int d, l, g, r, a, bs;
      rstn  = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      dly   = '0;
      len   = '0;
      gap   = '0;
      reps  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("reset_state", {pulse, busy, done}, 3'b000);
      rstn = 1'b1;
      @(negedge clk);
      check_eq("idle_after_reset", {pulse, busy, done}, 3'b000);

      // Delayed single pulse.
      build_model(3, 2, 0, 1, 0);
      run_burst(3, 2, 0, 1, -1, -1, 2);
      // Three short pulses with gaps.
      build_model(0, 1, 2, 3, 0);
      run_burst(0, 1, 2, 3, -1, -1, 2);
      // Merged pulses, then back-to-back start on the done cycle.
      build_model(0, 2, 0, 2, 0);
      run_burst(0, 2, 0, 2, -1, -1, 0);
      build_model(1, 1, 1, 2, 0);
      run_burst(1, 1, 1, 2, -1, -1, 2);
      // Continuous, aborted after 10 pulses.
      build_model(0, 1, 1, 0, 21);
      apply_abort(20);
      run_burst(0, 1, 1, 0, 20, -1, 3);
      // No pulse, done after the delay; a second start while busy is ignored.
      build_model(5, 0, 0, 1, 0);
      run_burst(5, 0, 0, 1, -1, 2, 3);
      // dly=0, len=0: done on the next cycle without ever going busy.
      build_model(0, 0, 3, 2, 0);
      run_burst(0, 0, 3, 2, -1, -1, 1);
      // Start and abort together: abort wins.
      build_model(2, 3, 1, 2, 0);
      apply_abort(0);
      run_burst(2, 3, 1, 2, 0, -1, 3);

      // Randomized bursts.
      for (int it = 0; it < 24; it++) begin
         d = $urandom_range(0, 5);
         l = $urandom_range(0, 4);
         g = $urandom_range(0, 3);
         r = $urandom_range(0, 4);
         a = -1;
         if (r == 0 && l != 0) begin
            a = $urandom_range(1, 25);
            build_model(d, l, g, r, a + 1);
            apply_abort(a);
         end else begin
            build_model(d, l, g, r, 0);
            if ($urandom_range(0, 3) == 0) begin
               a = $urandom_range(0, exp_q.size() - 1);
               apply_abort(a);
            end
         end
         bs = ($urandom_range(0, 1) == 1) ? pick_busy_start() : -1;
         run_burst(d, l, g, r, a, bs, $urandom_range(0, 2));
      end

      // Asynchronous reset in the middle of a long high level.
      dly   = 16'd0;
      len   = 16'd20;
      gap   = 16'd0;
      reps  = 8'd1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check_eq("rst_pre_high", {pulse, busy, done}, 3'b110);
      repeat (3) @(negedge clk);
      #2 rstn = 1'b0;
      #1 check_eq("rst_async_drop", {pulse, busy, done}, 3'b000);
      @(negedge clk);
      rstn = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_eq($sformatf("rst_idle_%0d", k), {pulse, busy, done}, 3'b000);
      end
      // Fresh burst after reset uses only the newly supplied config.
      build_model(1, 2, 1, 2, 0);
      run_burst(1, 2, 1, 2, -1, -1, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pulse_gen.md
Name: pulse_gen

Overview:
Programmable single-channel pulse/burst generator; the runtime-configurable successor of the fixed-parameter power-on pulse block.
- On a start strobe it waits a programmable delay, then emits a programmable number of pulses with programmable high length and inter-pulse gap. It can also run continuously until aborted.
- Used for reset sequencing, strobe generation and stimulus timing inside the same clock domain.

Parameters:
CW, 16, width of the delay/length/gap fields and of the internal down-counter
RW, 8, width of the repetition-count field

Ports:
clk  in  1  single clock; all logic on posedge
rstn  in  1  reset, asynchronous, active-low
start  in  1  1-cycle strobe; starts a burst when idle, ignored when busy
abort  in  1  stops any burst immediately; highest priority
dly  in  CW  cycles from start edge to first pulse rise
len  in  CW  high cycles per pulse; 0 means no pulse is emitted
gap  in  CW  low cycles between pulses; 0 means pulses merge into one high level
reps  in  RW  number of pulses; 0 means continuous until abort
pulse  out  1  registered pulse output
busy  out  1  high whenever the FSM is not IDLE
done  out  1  registered 1-cycle strobe at normal burst completion

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE; pulse=0, done=0, busy=0; counters=0; latched config=0.
- Config latch: dly/len/gap/reps are captured at the accepted start edge. Input changes while busy have no effect.
- FSM states: IDLE, DELAY, HIGH, GAP.
- Internal counters:
  - cnt: CW-bit down-counter.
  - rem: RW-bit remaining-pulse count, loaded with reps at start.
- done defaults to 0 every cycle unless set below.
- IDLE, start=1, abort=0 (edge E0), first matching rule applies:
  - dly!=0 -> DELAY, cnt=dly-1.
  - dly==0 and len!=0 -> HIGH, pulse=1, cnt=len-1.
  - dly==0 and len==0 -> stay IDLE, done=1.
- DELAY, cnt!=0: cnt-1.
- DELAY, cnt==0:
  - len!=0 -> HIGH, pulse=1, cnt=len-1.
  - len==0 -> IDLE, done=1.
- HIGH, cnt!=0: cnt-1.
- HIGH, cnt==0 (pulse end), first matching rule applies:
  - rem==1 -> IDLE, pulse=0, done=1.
  - gap==0 -> stay HIGH, pulse stays 1, cnt=len-1, rem decremented.
  - otherwise -> GAP, pulse=0, cnt=gap-1, rem decremented.
- Continuous mode (reps==0): rem never decrements and "last" is never reached.
- GAP, cnt!=0: cnt-1.
- GAP, cnt==0: HIGH, pulse=1, cnt=len-1.
- Resulting timing:
  - pulse first rises at edge E0+dly.
  - Each pulse is high for exactly len cycles.
  - Each gap is low for exactly gap cycles.
  - done is high for the cycle following the last high cycle.
- busy is combinational from state (state!=IDLE). It is low in the cycle where done=1.
- abort=1 in any state: next state IDLE, pulse=0, done=0 (aborted bursts never raise done), counters cleared.
- abort and start in the same cycle: abort wins and start is dropped.
- start while busy: ignored. No queuing.
- start in the same cycle done=1: accepted, because the FSM is already IDLE.
- Reset mid-burst: immediate return to the reset values listed above, independent of clk.
- Arithmetic: all counters are unsigned. There is no wrap-around, since every decrement is guarded by !=0. Max delay is 2^CW-1 cycles.

Decomposition:
- Package pulse_gen_pkg:
  - state enum (IDLE, DELAY, HIGH, GAP);
  - default CW/RW constants;
  - helper function is_last(rem, continuous).
- One sub-module, pulse_cnt_dn: a loadable CW-bit down-counter.
  - Ports: clk, rstn, load, load_val, en; output zero flag.
  - Instantiated once for cnt.
- rem stays inline.

Test Plan:
- dly=3, len=2, gap=0, reps=1; start at E0 -> pulse high after E3 and E4 (2 cycles), low after E5; done=1 for one cycle after E5; busy high after E0..E4.
- dly=0, len=1, gap=2, reps=3 -> pulse pattern from E0: 1,0,0,1,0,0,1 then low; done exactly once, in the cycle after the third high cycle.
- dly=0, len=2, gap=0, reps=2 -> single merged 4-cycle high level, then done.
- reps=0, len=1, gap=1; abort after 10 pulses -> pulse alternates 1/0 until abort; pulse=0 and busy=0 the cycle after abort; done never asserted.
- len=0, dly=5 -> pulse never asserts; done after 5 cycles. Second start issued while busy -> ignored, only one done observed.
- Deassert rstn mid-HIGH -> pulse, busy and done drop asynchronously. After release, the FSM sits in IDLE until the next start, and stale config is not reused.
